// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the MixColumns stage.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_col_t;
    typedef logic [7:0]   aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    localparam aes_byte_t AES_POLY = 8'h1B;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column, row 0 in the MSB byte.
// MIX_COLUMNS_INV_EN adds inv_i selecting the inverse matrix.
module mix_single_column
    import aes_pkg::*;
(
    input  aes_col_t col_i,
`ifdef MIX_COLUMNS_INV_EN
    input  logic     inv_i,
`endif
    output aes_col_t col_o
);

    aes_byte_t a_s  [4];
    aes_byte_t x2_s [4];
    aes_byte_t fwd_s[4];
`ifdef MIX_COLUMNS_INV_EN
    aes_byte_t x4_s [4];
    aes_byte_t x8_s [4];
    aes_byte_t inv_s[4];
`endif

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign a_s[i]  = col_i[31-8*i -: 8];
        assign x2_s[i] = xtime(a_s[i]);
`ifdef MIX_COLUMNS_INV_EN
        assign x4_s[i] = xtime(x2_s[i]);
        assign x8_s[i] = xtime(x4_s[i]);
`endif
    end

    // Each output row is the circulant matrix row rotated by its index.
    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam int R1 = (r + 1) % 4;
        localparam int R2 = (r + 2) % 4;
        localparam int R3 = (r + 3) % 4;

        assign fwd_s[r] = x2_s[r] ^ (x2_s[R1] ^ a_s[R1]) ^ a_s[R2] ^ a_s[R3];
`ifdef MIX_COLUMNS_INV_EN
        assign inv_s[r] = (x2_s[r]  ^ x4_s[r]  ^ x8_s[r])
                        ^ (a_s[R1]  ^ x2_s[R1] ^ x8_s[R1])
                        ^ (a_s[R2]  ^ x4_s[R2] ^ x8_s[R2])
                        ^ (a_s[R3]  ^ x8_s[R3]);
        assign col_o[31-8*r -: 8] = inv_i ? inv_s[r] : fwd_s[r];
`else
        assign col_o[31-8*r -: 8] = fwd_s[r];
`endif
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns stage: COLS_PER_CYCLE columns per clock, valid/ready
// on both sides, per-transfer bypass. MIX_COLUMNS_INV_EN adds in_inv (InvMixColumns).
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
`ifdef MIX_COLUMNS_INV_EN
    input  logic         in_inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int         N        = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(N - 1);

    mc_state_t  state_q;
    aes_state_t data_q;
    aes_state_t mixed_d;
    logic [1:0] col_cnt_q;
    logic       bypass_q;
    logic       ready_en_q;
    logic       out_valid_q;
    logic       accept_s;
`ifdef MIX_COLUMNS_INV_EN
    logic       inv_q;
`endif

    logic [1:0] col_idx_s [COLS_PER_CYCLE];
    aes_col_t   col_in_s  [COLS_PER_CYCLE];
    aes_col_t   col_out_s [COLS_PER_CYCLE];

    // Column mux: slot j works on column col_cnt*COLS_PER_CYCLE + j.
    for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
        assign col_idx_s[j] = 2'(32'(col_cnt_q) * COLS_PER_CYCLE + j);
        assign col_in_s[j]  = data_q[{col_idx_s[j], 5'd0} +: 32];

        mix_single_column u_mix (
            .col_i (col_in_s[j]),
`ifdef MIX_COLUMNS_INV_EN
            .inv_i (inv_q),
`endif
            .col_o (col_out_s[j])
        );
    end

    // Merge the freshly mixed columns back into the working state.
    always_comb begin
        mixed_d = data_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            mixed_d[{col_idx_s[j], 5'd0} +: 32] = col_out_s[j];
        end
    end

    // Input readiness; held low until the first clock after reset release.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            IDLE:    in_ready = ready_en_q;
            BUSY:    in_ready = 1'b0;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            col_cnt_q   <= 2'd0;
            bypass_q    <= 1'b0;
            ready_en_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            ready_en_q <= 1'b1;
            if (accept_s) begin
                // Covers both a fresh start from IDLE and pop-plus-accept in DONE.
                data_q      <= in_data;
                bypass_q    <= in_bypass;
                col_cnt_q   <= 2'd0;
                state_q     <= in_bypass ? DONE : BUSY;
                out_valid_q <= in_bypass;
`ifdef MIX_COLUMNS_INV_EN
                inv_q       <= in_inv;
`endif
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    BUSY: begin
                        if (!bypass_q) begin
                            data_q <= mixed_d;
                        end
                        if (col_cnt_q == LAST_CNT) begin
                            col_cnt_q   <= 2'd0;
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            col_cnt_q <= col_cnt_q + 2'd1;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
